// File: rtl/hsi_pkg.sv
// Shared HSI link definitions: line levels, frame geometry, gap limits and
// the encoder state type.
package hsi_pkg;

  localparam int LSB_FST = 0;
  localparam int MSB_FST = 1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic ON        = 1'b1;
  localparam logic OFF       = 1'b0;

  localparam int FRAME_BITS    = 10;
  localparam int DEF_BIT_TICKS = 8;

  // An idle run of this many clocks is taken by the receiver as msg_end.
  localparam int MSG_END_CHECK_TIME = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_GAP,
    ST_MSG_GAP
  } enc_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/encoder_if.sv
// Byte handshake between the message source (master) and the encoder (slave).
interface encoder_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/encoder.sv
// HSI serial frame transmitter: one-byte holding register feeding a
// start/8 data/odd-parity serialiser with intra- and end-of-message gaps.
module encoder
  import hsi_pkg::*;
#(
  parameter int ML_FST    = LSB_FST,
  parameter int BIT_TICKS = DEF_BIT_TICKS,
  parameter int INTRA_GAP = 1,
  parameter int MSG_GAP   = 8
) (
  input  logic      clk,
  input  logic      rst,
  encoder_if.slave  bus,
  output logic      q,
  output logic      busy,
  output logic      msg_done,
  output logic      underrun
);

  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int GW = $clog2(max_int(INTRA_GAP, MSG_GAP) + 1);

  if (INTRA_GAP >= MSG_END_CHECK_TIME) begin : g_chk_intra
    $error("encoder: INTRA_GAP must be below MSG_END_CHECK_TIME");
  end
  if (MSG_GAP <= MSG_END_CHECK_TIME) begin : g_chk_msg
    $error("encoder: MSG_GAP must exceed MSG_END_CHECK_TIME");
  end
  if (BIT_TICKS < 2) begin : g_chk_ticks
    $error("encoder: BIT_TICKS must be at least 2");
  end

  enc_state_t    state;
  logic [TW-1:0] tick;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par;
  logic          last_f;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic          hold_vld;
  logic          ur_done;

  logic take;
  logic tick_end;
  logic gap_end;
  logic load_now;

  function automatic logic out_bit(input logic [7:0] s);
    return (ML_FST == MSB_FST) ? s[7] : s[0];
  endfunction

  function automatic logic [7:0] shift(input logic [7:0] s);
    return (ML_FST == MSB_FST) ? {s[6:0], 1'b0} : {1'b0, s[7:1]};
  endfunction

  assign bus.ready = ~hold_vld;
  assign busy      = (state != ST_IDLE);
  assign take      = bus.valid & ~hold_vld;
  assign tick_end  = (tick == TW'(BIT_TICKS - 1));
  assign gap_end   = (gap_cnt == GW'(INTRA_GAP - 1));

  // With INTRA_GAP = 0 a held byte starts straight out of PARITY; an empty
  // holding register then falls into GAP already flagged as underrun.
  always_comb begin
    load_now = 1'b0;
    unique case (state)
      ST_IDLE:   load_now = hold_vld;
      ST_PARITY: load_now = tick_end & ~last_f & (INTRA_GAP == 0) & hold_vld;
      ST_GAP:    load_now = hold_vld & (ur_done | gap_end);
      default:   load_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      q         <= STOP_BIT;
      msg_done  <= OFF;
      underrun  <= OFF;
      tick      <= '0;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      last_f    <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_vld  <= OFF;
      ur_done   <= OFF;
    end else begin
      msg_done <= OFF;
      underrun <= OFF;

      if (take) begin
        hold_data <= bus.data;
        hold_last <= bus.last;
        hold_vld  <= ON;
      end

      if (load_now) begin
        shreg    <= hold_data;
        par      <= ~^hold_data;
        last_f   <= hold_last;
        hold_vld <= OFF;
        q        <= START_BIT;
        tick     <= '0;
        state    <= ST_START;
      end else begin
        unique case (state)
          ST_IDLE: q <= STOP_BIT;

          ST_START: begin
            if (tick_end) begin
              tick    <= '0;
              bit_idx <= '0;
              q       <= out_bit(shreg);
              shreg   <= shift(shreg);
              state   <= ST_DATA;
            end else begin
              tick <= tick + 1'b1;
            end
          end

          ST_DATA: begin
            if (tick_end) begin
              tick <= '0;
              if (bit_idx == 3'd7) begin
                q     <= par;
                state <= ST_PARITY;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                q       <= out_bit(shreg);
                shreg   <= shift(shreg);
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end

          ST_PARITY: begin
            if (tick_end) begin
              tick    <= '0;
              gap_cnt <= '0;
              q       <= STOP_BIT;
              ur_done <= OFF;
              if (last_f) begin
                state <= ST_MSG_GAP;
              end else begin
                state <= ST_GAP;
                if (INTRA_GAP == 0) begin
                  underrun <= ON;
                  ur_done  <= ON;
                end
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end

          ST_GAP: begin
            q <= STOP_BIT;
            if (!ur_done) begin
              if (gap_end) begin
                underrun <= ON;
                ur_done  <= ON;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end

          ST_MSG_GAP: begin
            q <= STOP_BIT;
            if (gap_cnt == GW'(MSG_GAP - 1)) begin
              msg_done <= ON;
              gap_cnt  <= '0;
              state    <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_encoder.sv
// Bench for encoder: an LSB-first and an MSB-first instance, a line decoder
// that turns q back into frames, and directed plus random message checks.
module tb_encoder;
  import hsi_pkg::*;

  localparam int BT  = 8;
  localparam int IG  = 1;
  localparam int MG  = 8;
  localparam int BIG = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  encoder_if if_l ();
  encoder_if if_m ();

  logic [7:0] dat [2];
  logic [1:0] vld, lst;
  logic [1:0] qv, bz, md, ur, rdy;

  assign if_l.data  = dat[0];
  assign if_l.valid = vld[0];
  assign if_l.last  = lst[0];
  assign if_m.data  = dat[1];
  assign if_m.valid = vld[1];
  assign if_m.last  = lst[1];
  assign rdy        = {if_m.ready, if_l.ready};

  encoder #(.ML_FST(LSB_FST), .BIT_TICKS(BT), .INTRA_GAP(IG), .MSG_GAP(MG)) dut_l (
    .clk(clk), .rst(rst), .bus(if_l),
    .q(qv[0]), .busy(bz[0]), .msg_done(md[0]), .underrun(ur[0])
  );

  encoder #(.ML_FST(MSB_FST), .BIT_TICKS(BT), .INTRA_GAP(IG), .MSG_GAP(MG)) dut_m (
    .clk(clk), .rst(rst), .bus(if_m),
    .q(qv[1]), .busy(bz[1]), .msg_done(md[1]), .underrun(ur[1])
  );

  typedef struct {
    logic [9:0] bits;
    logic       glitch;
    int         gap;
    int         start_cyc;
  } frame_t;

  frame_t fr0[$];
  frame_t fr1[$];

  bit         in_fr   [2] = '{0, 0};
  int         fcnt    [2] = '{0, 0};
  int         idle_run[2] = '{0, 0};
  int         gap_cur [2] = '{0, 0};
  int         st_cyc  [2] = '{0, 0};
  logic [9:0] bits_r  [2];
  logic       gl      [2] = '{1'b0, 1'b0};
  int         md_cnt  [2] = '{0, 0};
  int         md_cyc  [2] = '{0, 0};
  int         ur_cnt  [2] = '{0, 0};
  int         ur_cyc  [2] = '{0, 0};
  logic       bz_prev [2] = '{1'b0, 1'b0};
  int         bz_fall [2] = '{0, 0};

  int total = 0;
  int bad   = 0;

  // Line decoder: a low level on an idle line opens a frame of 10 bit
  // periods; every clock of a period must hold the level seen at its start.
  always @(negedge clk) begin
    frame_t nf;
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        in_fr[ch]    = 0;
        idle_run[ch] = 0;
        bz_prev[ch]  = 1'b0;
      end else begin
        if (md[ch]) begin md_cnt[ch]++; md_cyc[ch] = cyc; end
        if (ur[ch]) begin ur_cnt[ch]++; ur_cyc[ch] = cyc; end
        if (bz_prev[ch] && !bz[ch]) bz_fall[ch] = cyc;
        bz_prev[ch] = bz[ch];
        if (!in_fr[ch]) begin
          if (qv[ch] === 1'b0) begin
            in_fr[ch]   = 1;
            fcnt[ch]    = 0;
            gl[ch]      = 1'b0;
            gap_cur[ch] = idle_run[ch];
            st_cyc[ch]  = cyc;
          end else begin
            idle_run[ch]++;
          end
        end
        if (in_fr[ch]) begin
          if (fcnt[ch] % BT == 0) bits_r[ch][fcnt[ch] / BT] = qv[ch];
          else if (qv[ch] !== bits_r[ch][fcnt[ch] / BT]) gl[ch] = 1'b1;
          if (fcnt[ch] == FRAME_BITS * BT - 1) begin
            nf.bits      = bits_r[ch];
            nf.glitch    = gl[ch];
            nf.gap       = gap_cur[ch];
            nf.start_cyc = st_cyc[ch];
            if (ch == 1) fr1.push_back(nf); else fr0.push_back(nf);
            in_fr[ch]    = 0;
            idle_run[ch] = 0;
          end else begin
            fcnt[ch]++;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic int fr_size(input int ch);
    return (ch == 1) ? fr1.size() : fr0.size();
  endfunction

  function automatic frame_t fr_get(input int ch, input int idx);
    return (ch == 1) ? fr1[idx] : fr0[idx];
  endfunction

  // Reference reading of a frame: data bits in line order mapped by bit order.
  function automatic logic [7:0] decode(input int ch, input logic [9:0] bits);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      if (ch == 1) b[7 - i] = bits[1 + i];
      else         b[i]     = bits[1 + i];
    end
    return b;
  endfunction

  task automatic send(input int ch, input logic [7:0] d, input logic l, input bit keep, output int e);
    int budget = 400;
    dat[ch] = d;
    lst[ch] = l;
    vld[ch] = 1'b1;
    while (!rdy[ch] && budget > 0) begin step(); budget--; end
    check("send_ready", rdy[ch], 1);
    e = cyc + 1;
    step();
    check("ready_drop_after_accept", rdy[ch], 0);
    if (!keep) vld[ch] = 1'b0;
  endtask

  task automatic wait_frames(input int ch, input int n);
    int budget = 3000;
    while (fr_size(ch) < n && budget > 0) begin step(); budget--; end
    check("frame_count", fr_size(ch), n);
  endtask

  task automatic wait_idle(input int ch);
    int budget = 3000;
    while ((bz[ch] || !rdy[ch]) && budget > 0) begin step(); budget--; end
    check("reach_idle", bz[ch], 0);
  endtask

  task automatic wait_cyc(input int t);
    int budget = 3000;
    while (cyc < t && budget > 0) begin step(); budget--; end
    check("wait_cycle", cyc, t);
  endtask

  task automatic chk_frame(input string tag, input int ch, input int idx, input logic [7:0] eb,
                           input int est, input int gmin, input int gmax);
    frame_t     f;
    logic [7:0] b;
    if (idx >= fr_size(ch)) begin
      check({tag, "_missing"}, fr_size(ch), idx + 1);
      return;
    end
    f = fr_get(ch, idx);
    b = decode(ch, f.bits);
    check({tag, "_byte"}, b, eb);
    check({tag, "_parity"}, f.bits[9], ($countones(eb) % 2 == 0) ? 1 : 0);
    check({tag, "_glitch"}, f.glitch, 0);
    if (est >= 0) check({tag, "_start_cyc"}, f.start_cyc, est);
    if (gmin == gmax) check({tag, "_gap"}, f.gap, gmin);
    else check({tag, "_gap_range"}, (f.gap >= gmin && f.gap <= gmax), 1);
  endtask

  initial begin
    int         e, e2, e3, n, m0, u0, s1, nb, idles;
    logic [7:0] b;
    logic [7:0] rb [3];
    logic [7:0] eq[$];
    bit         first_q[$];

    vld    = '0;
    lst    = '0;
    dat[0] = '0;
    dat[1] = '0;

    // Reset state, and transfers attempted during reset are dropped
    step();
    step();
    check("rst_q", qv, 2'b11);
    check("rst_busy", bz, 2'b00);
    check("rst_ready", rdy, 2'b11);
    check("rst_msg_done", md, 2'b00);
    check("rst_underrun", ur, 2'b00);
    vld = 2'b11;
    step();
    vld = '0;
    check("rst_ready_ignored", rdy, 2'b11);
    rst = 1'b0;
    step();
    step();
    check("post_rst_line", qv, 2'b11);
    check("post_rst_busy", bz, 2'b00);

    // 1: LSB-first 0xA5 as a one-byte message
    m0 = md_cnt[0];
    send(0, 8'hA5, 1'b1, 1'b0, e);
    wait_frames(0, 1);
    chk_frame("t1", 0, 0, 8'hA5, e + 1, 0, BIG);
    wait_idle(0);
    check("t1_msg_done_cyc", md_cyc[0], e + 89);
    check("t1_msg_done_cnt", md_cnt[0] - m0, 1);
    check("t1_busy_fall_cyc", bz_fall[0], e + 89);
    step();
    check("t1_msg_done_pulse", md[0], 0);

    // 2: MSB-first 0x80
    m0 = md_cnt[1];
    send(1, 8'h80, 1'b1, 1'b0, e);
    wait_frames(1, 1);
    chk_frame("t2", 1, 0, 8'h80, e + 1, 0, BIG);
    check("t2_first_data_bit", fr1[0].bits[1], 1);
    wait_idle(1);
    check("t2_msg_done_cnt", md_cnt[1] - m0, 1);

    // 3: two-byte message with valid held
    n  = fr0.size();
    m0 = md_cnt[0];
    u0 = ur_cnt[0];
    send(0, 8'h00, 1'b0, 1'b1, e);
    send(0, 8'hFF, 1'b1, 1'b0, e2);
    wait_frames(0, n + 2);
    chk_frame("t3a", 0, n, 8'h00, e + 1, 0, BIG);
    chk_frame("t3b", 0, n + 1, 8'hFF, -1, IG, IG);
    wait_idle(0);
    check("t3_msg_done_cnt", md_cnt[0] - m0, 1);
    check("t3_underrun_cnt", ur_cnt[0] - u0, 0);

    // 4: source stalls 20 clocks after the parity bit
    n  = fr0.size();
    u0 = ur_cnt[0];
    send(0, 8'h3C, 1'b0, 1'b0, e);
    wait_frames(0, n + 1);
    s1 = fr0[n].start_cyc;
    wait_cyc(s1 + FRAME_BITS * BT + 20);
    send(0, 8'hE7, 1'b1, 1'b0, e2);
    wait_frames(0, n + 2);
    chk_frame("t4a", 0, n, 8'h3C, e + 1, 0, BIG);
    chk_frame("t4b", 0, n + 1, 8'hE7, e2 + 1, 22, 22);
    check("t4_underrun_cnt", ur_cnt[0] - u0, 1);
    check("t4_underrun_cyc", ur_cyc[0], s1 + FRAME_BITS * BT + IG);
    wait_idle(0);

    // 5: reset 40 clocks into a frame with another byte held
    n = fr0.size();
    send(0, 8'hC3, 1'b1, 1'b0, e);
    send(0, 8'h11, 1'b1, 1'b0, e2);
    wait_cyc(e + 40);
    rst = 1'b1;
    #1;
    check("t5_rst_q", qv[0], 1);
    check("t5_rst_busy", bz[0], 0);
    check("t5_rst_ready", rdy[0], 1);
    step();
    step();
    check("t5_aborted_frame", fr0.size(), n);
    rst = 1'b0;
    step();
    m0 = md_cnt[0];
    send(0, 8'h5A, 1'b1, 1'b0, e);
    wait_frames(0, n + 1);
    chk_frame("t5", 0, n, 8'h5A, e + 1, 0, BIG);
    wait_idle(0);
    check("t5_msg_done_cnt", md_cnt[0] - m0, 1);
    check("t5_no_stale_byte", fr0.size(), n + 1);

    // 6: three queued bytes, valid held throughout
    n  = fr0.size();
    m0 = md_cnt[0];
    u0 = ur_cnt[0];
    for (int i = 0; i < 3; i++) rb[i] = 8'($urandom);
    send(0, rb[0], 1'b0, 1'b1, e);
    send(0, rb[1], 1'b0, 1'b1, e2);
    send(0, rb[2], 1'b1, 1'b0, e3);
    check("t6_second_accept", e2 - e, 2);
    wait_frames(0, n + 3);
    check("t6_third_accept", e3, fr0[n + 1].start_cyc + 1);
    chk_frame("t6a", 0, n, rb[0], e + 1, 0, BIG);
    chk_frame("t6b", 0, n + 1, rb[1], -1, IG, IG);
    chk_frame("t6c", 0, n + 2, rb[2], -1, IG, IG);
    wait_idle(0);
    check("t6_msg_done_cnt", md_cnt[0] - m0, 1);
    check("t6_underrun_cnt", ur_cnt[0] - u0, 0);

    // Random messages on both bit orders
    for (int ch = 0; ch < 2; ch++) begin
      n  = fr_size(ch);
      m0 = md_cnt[ch];
      u0 = ur_cnt[ch];
      eq.delete();
      first_q.delete();
      for (int m = 0; m < 4; m++) begin
        nb = $urandom_range(1, 3);
        for (int j = 0; j < nb; j++) begin
          b = 8'($urandom);
          send(ch, b, (j == nb - 1), (j != nb - 1), e);
          eq.push_back(b);
          first_q.push_back(j == 0);
        end
        idles = $urandom_range(0, 25);
        for (int k = 0; k < idles; k++) step();
      end
      wait_idle(ch);
      wait_frames(ch, n + eq.size());
      for (int i = 0; i < eq.size(); i++) begin
        if (i == 0) chk_frame("rnd_first", ch, n + i, eq[i], -1, 0, BIG);
        else if (first_q[i]) chk_frame("rnd_msg_start", ch, n + i, eq[i], -1, MG + 1, BIG);
        else chk_frame("rnd_in_msg", ch, n + i, eq[i], -1, IG, IG);
      end
      check("rnd_msg_done_cnt", md_cnt[ch] - m0, 4);
      check("rnd_underrun_cnt", ur_cnt[ch] - u0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
